// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared mode encoding and sizing helpers for the pipelined adder
package adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   // Pipeline depth: one stage per CHUNK-bit slice
   function automatic int stages(input int width, input int chunk);
      return (chunk > 0) ? (width / chunk) : 1;
   endfunction

   // Legal slicing: chunk in 1..width and width an exact multiple of chunk
   function automatic bit chunking_ok(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operation/result bundle for the pipelined adder
interface pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] c;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, sub, a, b, cin,
      input  out_valid, c, cout, ovf
   );

   modport slave (
      input  in_valid, sub, a, b, cin,
      output out_valid, c, cout, ovf
   );
endinterface

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one CHUNK-bit slice of the pipelined adder
module adder_stage #(
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             carry_i,
   output logic             valid_o,
   output logic [CHUNK-1:0] sum_o,
   output logic             carry_o
);
   logic             valid_q;
   logic [CHUNK-1:0] sum_q;
   logic [CHUNK-1:0] sum_d;
   logic             carry_q;
   logic             carry_d;

   // Slice add; the carry out is registered and becomes the next stage's carry in
   always_comb begin
      {carry_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
   end

   // Valid advances every cycle; data loads only under its valid so results hold across bubbles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign sum_o   = sum_q;
   assign carry_o = carry_q;
endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined chunked add/subtract unit with skew/deskew registers
module pipe_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic         clk,
   input logic         rst_n,
   pipe_adder_if.slave bus
);
   localparam int STAGES = stages(WIDTH, CHUNK);

   if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_params
      $error("pipe_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
   end

   logic [WIDTH-1:0] bp_w;
   logic             cin_eff_w;
   logic [STAGES:0]  valid_w;
   logic [STAGES:0]  carry_w;
   logic [CHUNK-1:0] a_st_w   [STAGES];
   logic [CHUNK-1:0] bp_st_w  [STAGES];
   logic [CHUNK-1:0] sum_st_w [STAGES];
   logic [WIDTH-1:0] c_w;
   logic             a_msb_q;
   logic             bp_msb_q;

   // Subtract is an add of ~b with the carry-in inverted (borrow-in becomes !carry)
   always_comb begin
      bp_w      = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
      cin_eff_w = (bus.sub == MODE_SUB) ? ~bus.cin : bus.cin;
   end

   assign valid_w[0] = bus.in_valid;
   assign carry_w[0] = cin_eff_w;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int DLY = STAGES - 1 - k;

      if (k == 0) begin : g_noskew
         assign a_st_w[k]  = bus.a[CHUNK-1:0];
         assign bp_st_w[k] = bp_w[CHUNK-1:0];
      end else begin : g_skew
         logic [CHUNK-1:0] a_q  [k];
         logic [CHUNK-1:0] bp_q [k];

         // Delay slice k by k cycles so it meets the carry registered by stage k-1
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int j = 0; j < k; j++) begin
                  a_q[j]  <= '0;
                  bp_q[j] <= '0;
               end
            end else begin
               if (valid_w[0]) begin
                  a_q[0]  <= bus.a[k*CHUNK +: CHUNK];
                  bp_q[0] <= bp_w[k*CHUNK +: CHUNK];
               end
               for (int j = 1; j < k; j++) begin
                  if (valid_w[j]) begin
                     a_q[j]  <= a_q[j-1];
                     bp_q[j] <= bp_q[j-1];
                  end
               end
            end
         end

         assign a_st_w[k]  = a_q[k-1];
         assign bp_st_w[k] = bp_q[k-1];
      end

      adder_stage #(
         .CHUNK(CHUNK)
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .valid_i(valid_w[k]),
         .a_i    (a_st_w[k]),
         .b_i    (bp_st_w[k]),
         .carry_i(carry_w[k]),
         .valid_o(valid_w[k+1]),
         .sum_o  (sum_st_w[k]),
         .carry_o(carry_w[k+1])
      );

      if (DLY == 0) begin : g_nodeskew
         assign c_w[k*CHUNK +: CHUNK] = sum_st_w[k];
      end else begin : g_deskew
         logic [CHUNK-1:0] d_q [DLY];

         // Hold early result slices until the top slice finishes, gated by the travelling valid
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int j = 0; j < DLY; j++) begin
                  d_q[j] <= '0;
               end
            end else begin
               if (valid_w[k+1]) begin
                  d_q[0] <= sum_st_w[k];
               end
               for (int j = 1; j < DLY; j++) begin
                  if (valid_w[k+1+j]) begin
                     d_q[j] <= d_q[j-1];
                  end
               end
            end
         end

         assign c_w[k*CHUNK +: CHUNK] = d_q[DLY-1];
      end
   end

   // Sign bits of A and B' captured with the top slice so overflow lines up with the result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_msb_q  <= 1'b0;
         bp_msb_q <= 1'b0;
      end else if (valid_w[STAGES-1]) begin
         a_msb_q  <= a_st_w[STAGES-1][CHUNK-1];
         bp_msb_q <= bp_st_w[STAGES-1][CHUNK-1];
      end
   end

   assign bus.c         = c_w;
   assign bus.cout      = carry_w[STAGES];
   assign bus.out_valid = valid_w[STAGES];
   assign bus.ovf       = (a_msb_q == bp_msb_q) && (c_w[WIDTH-1] != a_msb_q);
endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder at 16/4 and 8/8
module tb_pipe_adder;
   import adder_pkg::*;

   localparam int HMAX = 2048;

   typedef struct {
      bit        v;
      bit [15:0] c;
      bit        co;
      bit        ov;
   } res_t;

   typedef struct {
      bit        rst;
      bit        v;
      bit        s;
      bit [15:0] a;
      bit [15:0] b;
      bit        ci;
   } hist_t;

   typedef struct {
      bit        s;
      bit [15:0] a;
      bit [15:0] b;
      bit        ci;
      bit [15:0] c16;
      bit        co16;
      bit        ov16;
      bit [7:0]  c8;
      bit        co8;
      bit        ov8;
   } vec_t;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        in_valid = 1'b0;
   logic        sub      = 1'b0;
   logic        cin      = 1'b0;
   logic [15:0] a        = '0;
   logic [15:0] b        = '0;

   int    checks   = 0;
   int    errors   = 0;
   int    edge_n   = 0;
   int    last_rst = -1;
   hist_t hist [HMAX];
   res_t  exp16;
   res_t  exp8;

   always #5 clk = ~clk;

   pipe_adder_if #(.WIDTH(16)) bus16 ();
   pipe_adder_if #(.WIDTH(8))  bus8 ();

   assign bus16.in_valid = in_valid;
   assign bus16.sub      = sub;
   assign bus16.a        = a;
   assign bus16.b        = b;
   assign bus16.cin      = cin;
   assign bus8.in_valid  = in_valid;
   assign bus8.sub       = sub;
   assign bus8.a         = a[7:0];
   assign bus8.b         = b[7:0];
   assign bus8.cin       = cin;

   pipe_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   pipe_adder #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Whole-word arithmetic reference: {cout,c} = a + B' + carry, overflow from sign bits
   function automatic res_t ref_op(input int w, input bit s, input bit [15:0] av,
                                   input bit [15:0] bv, input bit ci);
      res_t      r;
      bit [31:0] mask, aa, bb, full;
      mask = (32'd1 << w) - 32'd1;
      aa   = {16'd0, av} & mask;
      bb   = (s ? ~{16'd0, bv} : {16'd0, bv}) & mask;
      full = aa + bb + {31'd0, (s ? ~ci : ci)};
      r.v  = 1'b1;
      r.c  = full[15:0] & mask[15:0];
      r.co = full[w];
      r.ov = (aa[w-1] == bb[w-1]) && (r.c[w-1] != aa[w-1]);
      return r;
   endfunction

   // Timeline model: output after edge e is the op sampled at e-(lat-1), unless a reset intervened
   function automatic res_t model_step(input res_t prev, input int lat, input int w);
      res_t r;
      int   src;
      if (hist[edge_n].rst) begin
         r.v = 1'b0; r.c = '0; r.co = 1'b0; r.ov = 1'b0;
         return r;
      end
      src = edge_n - (lat - 1);
      if (src >= 0 && hist[src].v && last_rst < src) begin
         r = ref_op(w, hist[src].s, hist[src].a, hist[src].b, hist[src].ci);
      end else begin
         r   = prev;
         r.v = 1'b0;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (edge_n < HMAX) begin
         hist[edge_n] = '{!rst_n, in_valid, sub, a, b, cin};
         if (!rst_n) last_rst = edge_n;
         exp16 = model_step(exp16, 4, 16);
         exp8  = model_step(exp8, 1, 8);
         edge_n++;
      end
   end

   always @(negedge clk) begin
      if (edge_n > 0 && edge_n < HMAX) begin
         chk("sb16_valid", 16'(bus16.out_valid), 16'(exp16.v));
         chk("sb16_c",     bus16.c,               exp16.c);
         chk("sb16_cout",  16'(bus16.cout),       16'(exp16.co));
         chk("sb16_ovf",   16'(bus16.ovf),        16'(exp16.ov));
         chk("sb8_valid",  16'(bus8.out_valid),   16'(exp8.v));
         chk("sb8_c",      {8'd0, bus8.c},        exp8.c);
         chk("sb8_cout",   16'(bus8.cout),        16'(exp8.co));
         chk("sb8_ovf",    16'(bus8.ovf),         16'(exp8.ov));
      end
   end

   task automatic drive(input bit v, input bit s, input bit [15:0] av, input bit [15:0] bv,
                        input bit ci);
      @(negedge clk);
      in_valid = v;
      sub      = s;
      a        = av;
      b        = bv;
      cin      = ci;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid16"}, 16'(bus16.out_valid), 16'd0);
      chk({tag, "_c16"},     bus16.c,               16'd0);
      chk({tag, "_cout16"},  16'(bus16.cout),       16'd0);
      chk({tag, "_ovf16"},   16'(bus16.ovf),        16'd0);
      chk({tag, "_valid8"},  16'(bus8.out_valid),   16'd0);
      chk({tag, "_c8"},      {8'd0, bus8.c},        16'd0);
      chk({tag, "_cout8"},   16'(bus8.cout),        16'd0);
      chk({tag, "_ovf8"},    16'(bus8.ovf),         16'd0);
   endtask

   initial begin
      vec_t vt [6];
      int   bub;

      vt[0] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};
      vt[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[5] = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         drive(1'b1, vt[i].s, vt[i].a, vt[i].b, vt[i].ci);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid8", i), 16'(bus8.out_valid), 16'd1);
         chk($sformatf("vec%0d_c8", i),     {8'd0, bus8.c},      {8'd0, vt[i].c8});
         chk($sformatf("vec%0d_cout8", i),  16'(bus8.cout),      16'(vt[i].co8));
         chk($sformatf("vec%0d_ovf8", i),   16'(bus8.ovf),       16'(vt[i].ov8));
         drive_idle();
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid16", i), 16'(bus16.out_valid), 16'd1);
         chk($sformatf("vec%0d_c16", i),     bus16.c,              vt[i].c16);
         chk($sformatf("vec%0d_cout16", i),  16'(bus16.cout),      16'(vt[i].co16));
         chk($sformatf("vec%0d_ovf16", i),   16'(bus16.ovf),       16'(vt[i].ov16));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_gap16", i),  16'(bus16.out_valid), 16'd0);
         chk($sformatf("vec%0d_hold16", i), bus16.c,              vt[i].c16);
         chk($sformatf("vec%0d_hold8", i),  {8'd0, bus8.c},       {8'd0, vt[i].c8});
      end

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      end
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(posedge clk);
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      sub      = 1'b0;
      a        = 16'h1234;
      b        = 16'h0FF0;
      cin      = 1'b1;
      @(posedge clk);
      #1;
      chk("post_valid8", 16'(bus8.out_valid), 16'd1);
      chk("post_c8",     {8'd0, bus8.c},      16'h0025);
      chk("post_cout8",  16'(bus8.cout),      16'd1);
      chk("post_valid16_e1", 16'(bus16.out_valid), 16'd0);
      drive_idle();
      for (int i = 2; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_valid16_e%0d", i), 16'(bus16.out_valid), 16'd0);
      end
      @(posedge clk);
      #1;
      chk("post_valid16", 16'(bus16.out_valid), 16'd1);
      chk("post_c16",     bus16.c,              16'h2225);
      chk("post_cout16",  16'(bus16.cout),      16'd0);
      chk("post_ovf16",   16'(bus16.ovf),       16'd0);

      bub = $urandom_range(1, 7);
      for (int i = 0; i < 9; i++) begin
         if (i == bub) drive_idle();
         else drive(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      end
      drive_idle();
      repeat (5) @(posedge clk);

      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         rst_n    = ($urandom_range(0, 39) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         sub      = 1'($urandom);
         a        = 16'($urandom);
         b        = 16'($urandom);
         cin      = 1'($urandom);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
